// File: rtl/data_memory_bytelane_if.sv
// data_memory_bytelane_if: request/response bus of the byte-lane data memory
// master drives req_valid/req_we/req_funct3/req_addr/req_wdata, sees req_ready and resp_*
// slave (the memory) drives req_ready/resp_valid/resp_rdata/resp_err
interface data_memory_bytelane_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: RV32 data memory, byte-lane stores, extending loads, one-cycle registered response
// ports: clk, rst (async active-high), bus (slave modport: valid/ready request, resp_valid/rdata/err), init_done
// DMEM_MISALIGN_TRAP_EN defined: misaligned half/word accesses error out instead of being force-aligned
module data_memory_bytelane #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_bytelane_if.slave  bus,
  output logic                   init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [31:0]     r_mem [DEPTH];
  logic            r_resp_valid, r_resp_err;
  logic [31:0]     r_resp_rdata;
  logic            w_accept, w_illegal, w_misal, w_err, w_st, w_unused;
  logic [2:0]      w_f3;
  logic [1:0]      w_off;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_be;
  logic [31:0]     w_wdat, w_word, w_sh, w_ld, w_rdata;
  assign w_f3      = bus.req_funct3;
  assign w_idx     = bus.req_addr[AW+1:2];
  assign w_unused  = ^bus.req_addr[31:AW+2];
  assign w_accept  = bus.req_valid && r_state == RUN;
  assign w_illegal = bus.req_we ? !(w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010)
                                : (w_f3 == 3'b011 || w_f3[2:1] == 2'b11);
  assign w_misal   = (w_f3[1:0] == 2'b01 && bus.req_addr[0]) || (w_f3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_err     = w_illegal || w_misal;
`else
  assign w_err     = w_illegal;
`endif
  // natural alignment: words ignore addr[1:0], halves ignore addr[0]
  assign w_off     = w_f3[1:0] == 2'b10 ? 2'b00 : w_f3[1:0] == 2'b01 ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
  assign w_be      = w_f3[1:0] == 2'b00 ? 4'b0001 << w_off : w_f3[1:0] == 2'b01 ? 4'b0011 << w_off : 4'b1111;
  assign w_wdat    = bus.req_wdata << {w_off, 3'b000};
  assign w_st      = w_accept && bus.req_we && !w_err;
  assign w_word    = r_mem[w_idx];
  assign w_sh      = w_word >> {w_off, 3'b000};
  assign w_ld      = w_f3 == 3'b000 ? {{24{w_sh[7]}}, w_sh[7:0]}
                   : w_f3 == 3'b001 ? {{16{w_sh[15]}}, w_sh[15:0]}
                   : w_f3 == 3'b100 ? {24'b0, w_sh[7:0]}
                   : w_f3 == 3'b101 ? {16'b0, w_sh[15:0]}
                   : w_word;
  assign w_rdata   = (bus.req_we || w_err) ? '0 : w_ld;
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && &r_cnt) w_state_nxt = RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= r_state == INIT ? r_cnt + 1'b1 : r_cnt;
    end
  end
  // array has no reset; the INIT sweep defines its contents
  always_ff @(posedge clk) begin
    if (r_state == INIT) r_mem[r_cnt] <= '0;
    else if (w_st)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_rdata <= w_accept ? w_rdata : '0;
      r_resp_err   <= w_accept && w_err;
    end
  end
  assign bus.req_ready  = r_state == RUN;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign init_done      = r_state == RUN;
endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb_data_memory_bytelane: scoreboard bench for data_memory_bytelane
module tb_data_memory_bytelane;
  localparam int DEPTH = 1024;
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic init_done;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  data_memory_bytelane_if bus();
  data_memory_bytelane #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .init_done(init_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp rdata=%h err=%b required=no response", bus.resp_rdata, bus.resp_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err) begin
          failures++;
          $display("FAIL %s rdata=%h err=%b required rdata=%h err=%b", e.name, bus.resp_rdata, bus.resp_err, e.rdata, e.err);
        end
      end
    end else begin
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
        failures++;
        $display("FAIL idle_resp valid=%b rdata=%h err=%b required 0/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_err);
      end
    end
  end
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ee, input string nm);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready ready=%b required 1", nm, bus.req_ready);
    end
    q.push_back('{nm, er, ee});
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_sweep(input string nm);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < DEPTH + 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (n != DEPTH || init_done !== 1'b1) begin
      failures++;
      $display("FAIL %s cycles=%0d init_done=%b required cycles=%0d init_done=1", nm, n, init_done, DEPTH);
    end
  endtask
  task automatic check_reset_outputs(input string nm);
    checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.resp_err !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL %s ready=%b valid=%b rdata=%h err=%b init_done=%b required all 0", nm,
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, init_done);
    end
  endtask
  task automatic test_reset;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    bus.req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("init_sweep");
    for (int i = 0; i < 8; i++) send(1'b0, 3'b010, 32'(i * 4), '0, 32'h0, 1'b0, "lw_cleared");
    send(1'b0, 3'b010, 32'hFFC, '0, 32'h0, 1'b0, "lw_cleared_top");
    for (int i = 0; i < 6; i++) send(1'b0, 3'b010, {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'b00}, '0, 32'h0, 1'b0, "lw_cleared_rand");
    idle(2);
  endtask
  task automatic test_back_to_back;
    send(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 1'b0, "sw_0x10");
    send(1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0, "sb_0x11");
    send(1'b0, 3'b010, 32'h10, '0, 32'h1122AA44, 1'b0, "lw_merged");
    send(1'b1, 3'b001, 32'h16, 32'hFFFF5A5A, 32'h0, 1'b0, "sh_0x16");
    send(1'b0, 3'b010, 32'h14, '0, 32'h5A5A0000, 1'b0, "lw_half_lane");
    idle(2);
  endtask
  task automatic test_loads;
    send(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, "sw_0x20");
    send(1'b0, 3'b000, 32'h23, '0, 32'hFFFFFF80, 1'b0, "lb_0x23");
    send(1'b0, 3'b100, 32'h23, '0, 32'h00000080, 1'b0, "lbu_0x23");
    send(1'b0, 3'b001, 32'h22, '0, 32'hFFFF80FF, 1'b0, "lh_0x22");
    send(1'b0, 3'b101, 32'h20, '0, 32'h00007F01, 1'b0, "lhu_0x20");
    send(1'b0, 3'b001, 32'h20, '0, 32'h00007F01, 1'b0, "lh_0x20");
    send(1'b0, 3'b000, 32'h21, '0, 32'h0000007F, 1'b0, "lb_0x21");
    send(1'b0, 3'b101, 32'h22, '0, 32'h000080FF, 1'b0, "lhu_0x22");
    idle(2);
  endtask
  task automatic test_misalign;
    logic [31:0] w0 = 32'hCAFEF00D;
    send(1'b1, 3'b010, 32'h0, w0, 32'h0, 1'b0, "sw_0x0");
`ifdef DMEM_MISALIGN_TRAP_EN
    send(1'b0, 3'b010, 32'h4002, '0, 32'h0, 1'b1, "lw_0x4002_trap");
    send(1'b1, 3'b010, 32'h4001, 32'h12345678, 32'h0, 1'b1, "sw_misal_trap");
    send(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b1, "sh_misal_trap");
    send(1'b0, 3'b001, 32'h21, '0, 32'h0, 1'b1, "lh_misal_trap");
`else
    send(1'b0, 3'b010, 32'h4002, '0, w0, 1'b0, "lw_0x4002_wrap");
    send(1'b1, 3'b010, 32'h4001, 32'h12345678, 32'h0, 1'b0, "sw_misal_align");
    w0 = 32'h12345678;
    send(1'b1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 1'b0, "sh_misal_align");
    w0 = 32'hBEEF5678;
    send(1'b0, 3'b001, 32'h21, '0, 32'h00007F01, 1'b0, "lh_misal_align");
`endif
    send(1'b0, 3'b010, 32'h0, '0, w0, 1'b0, "lw_0x0_after");
    idle(2);
  endtask
  task automatic test_illegal;
    send(1'b1, 3'b010, 32'h30, 32'h55667788, 32'h0, 1'b0, "sw_0x30");
    send(1'b1, 3'b011, 32'h30, 32'hDEADBEEF, 32'h0, 1'b1, "sw_f3_011");
    send(1'b1, 3'b100, 32'h30, 32'hDEADBEEF, 32'h0, 1'b1, "sw_f3_100");
    send(1'b0, 3'b010, 32'h30, '0, 32'h55667788, 1'b0, "lw_0x30_unchanged");
    send(1'b0, 3'b011, 32'h30, '0, 32'h0, 1'b1, "ld_f3_011");
    send(1'b0, 3'b110, 32'h30, '0, 32'h0, 1'b1, "ld_f3_110");
    send(1'b0, 3'b111, 32'h30, '0, 32'h0, 1'b1, "ld_f3_111");
    idle(2);
  endtask
  task automatic test_reset_mid_run;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("resweep");
    send(1'b0, 3'b010, 32'h10, '0, 32'h0, 1'b0, "lw_0x10_cleared");
    send(1'b0, 3'b010, 32'h20, '0, 32'h0, 1'b0, "lw_0x20_cleared");
    send(1'b0, 3'b010, 32'h30, '0, 32'h0, 1'b0, "lw_0x30_cleared");
    idle(3);
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_loads;
    test_misalign;
    test_illegal;
    test_reset_mid_run;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
